// File: rtl/io_timer_if.sv
// CPU-side bus bundle for the timer: write/read-strobe inputs, busy/data/irq outputs.
interface io_timer_if;
  logic        cs;
  logic [1:0]  addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic        rd_strobe;
  logic        rd_busy;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output cs, addr, wmask, wdata, rd_strobe,
    input  rd_busy, rdata, irq
  );

  modport slave (
    input  cs, addr, wmask, wdata, rd_strobe,
    output rd_busy, rdata, irq
  );
endinterface

// File: rtl/io_timer.sv
// Prescaled 32-bit down-counter timer on the FemtoRV32 IO bus with level irq on expiry.
// Writes land at the next edge; reads hold rd_busy READ_WAIT cycles, rdata valid as it falls.
module io_timer #(
  parameter int PRESCALE  = 10,
  parameter int READ_WAIT = 1
) (
  input  logic      clk,
  input  logic      reset,
  io_timer_if.slave bus
);
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_WAIT   = 2'd1;
  localparam logic [1:0]  ST_DONE   = 2'd2;
  localparam logic [31:0] PRE_LAST  = 32'(PRESCALE - 1);
  localparam logic [2:0]  WAIT_INIT = 3'(READ_WAIT);

  logic        en, auto_rl, ie, exp_flag;
  logic [31:0] reload, count, pre;
  logic [1:0]  state, rd_addr;
  logic [2:0]  wait_cnt;
  logic        busy_q, irq_q;
  logic [31:0] rdata_q;

  logic        wr, wr_ctrl, wr_stat, wr_rel, wr_cnt, tick, expire;
  logic [31:0] cnt_merge, rel_merge, sel_val;
  logic [1:0]  sel_addr;

  always_comb begin
    wr        = bus.cs && (bus.wmask != 4'b0);
    wr_ctrl   = wr && (bus.addr == 2'd0) && bus.wmask[0];
    wr_stat   = wr && (bus.addr == 2'd1) && bus.wmask[0];
    wr_rel    = wr && (bus.addr == 2'd2);
    wr_cnt    = wr && (bus.addr == 2'd3);
    tick      = en && (pre == PRE_LAST);
    expire    = tick && (count == 32'd0);
    cnt_merge = count;
    rel_merge = reload;
    for (int b = 0; b < 4; b++) begin
      if (bus.wmask[b]) begin
        cnt_merge[8*b +: 8] = bus.wdata[8*b +: 8];
        rel_merge[8*b +: 8] = bus.wdata[8*b +: 8];
      end
    end
    // With zero wait states the read completes on the strobe edge, before addr is latched.
    sel_addr = (state == ST_IDLE) ? bus.addr : rd_addr;
    case (sel_addr)
      2'd0:    sel_val = {29'd0, ie, auto_rl, en};
      2'd1:    sel_val = {31'd0, exp_flag};
      2'd2:    sel_val = reload;
      default: sel_val = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      exp_flag <= 1'b0;
      reload   <= 32'd0;
      count    <= 32'd0;
      pre      <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      // Held at 0 while disabled, so an EN 0->1 write always starts a fresh period.
      if (!en || tick) pre <= 32'd0;
      else             pre <= pre + 32'd1;

      if (tick) begin
        if (count != 32'd0) begin
          count <= count - 32'd1;
        end else begin
          exp_flag <= 1'b1;
          if (auto_rl) count <= reload;
          else         en    <= 1'b0;
        end
      end

      if (wr_ctrl) begin
        en      <= bus.wdata[0];
        auto_rl <= bus.wdata[1];
        ie      <= bus.wdata[2];
      end
      if (wr_stat && bus.wdata[0] && !expire) exp_flag <= 1'b0;
      if (wr_rel) reload <= rel_merge;
      if (wr_cnt) count  <= cnt_merge;

      irq_q <= exp_flag && ie;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      rd_addr  <= 2'd0;
      wait_cnt <= 3'd0;
      busy_q   <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cs && bus.rd_strobe) begin
            rd_addr <= bus.addr;
            if (WAIT_INIT == 3'd0) begin
              rdata_q <= sel_val;
              state   <= ST_DONE;
            end else begin
              wait_cnt <= WAIT_INIT;
              busy_q   <= 1'b1;
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            rdata_q <= sel_val;
            busy_q  <= 1'b0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_busy = busy_q;
  assign bus.rdata   = rdata_q;
  assign bus.irq     = irq_q;
endmodule
